// File: rtl/grid_port_arbiter_if.sv
// Requester-side bus of the placement RAM arbiter: packed per-requester commands plus grant/return.
interface grid_port_arbiter_if #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = 32,
   parameter int unsigned DW   = 32
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    we;
   logic [NREQ-1:0]    lock;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;

   modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/grid_port_arbiter.sv
// Round-robin arbiter sharing one single-port placement RAM between NREQ engines,
// with a lock for atomic read-check-write and tagged read-data return.
module grid_port_arbiter #(
   parameter int unsigned NREQ   = 2,
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   grid_port_arbiter_if.slave   rq,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [AW-1:0]        mem_addr,
   output logic [DW-1:0]        mem_din,
   input  logic [DW-1:0]        mem_dout
);
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

   state_e          state_q;
   logic [IW-1:0]   ptr_q;
   logic [IW-1:0]   owner_q;
   logic            mem_read_q;
   logic            mem_write_q;
   logic [AW-1:0]   mem_addr_q;
   logic [DW-1:0]   mem_din_q;
   logic [RD_LAT:0] tag_vld_q;
   logic [IW-1:0]   tag_id_q [RD_LAT+1];

   logic [NREQ-1:0] gnt_c;
   logic [IW-1:0]   acc_idx_c;
   logic            accept_c;
   logic            acc_we_c;
   logic            acc_lock_c;
   logic [AW-1:0]   acc_addr_c;
   logic [DW-1:0]   acc_wdata_c;

   // Grant: owner only while locked, otherwise first request after the RR pointer.
   always_comb begin : grant_sel
      int unsigned cand;
      gnt_c     = '0;
      acc_idx_c = '0;
      cand      = 0;
      if (reset) begin
         if (state_q == ST_LOCKED) begin
            if (rq.req[owner_q]) begin
               gnt_c[owner_q] = 1'b1;
               acc_idx_c      = owner_q;
            end
         end else begin
            for (int unsigned i = 1; i <= NREQ; i++) begin
               cand = (32'(ptr_q) + i) % NREQ;
               if ((gnt_c == '0) && rq.req[IW'(cand)]) begin
                  gnt_c[IW'(cand)] = 1'b1;
                  acc_idx_c        = IW'(cand);
               end
            end
         end
      end
   end

   assign accept_c    = |gnt_c;
   assign acc_we_c    = rq.we[acc_idx_c];
   assign acc_lock_c  = rq.lock[acc_idx_c];
   assign acc_addr_c  = rq.addr[32'(acc_idx_c)*AW +: AW];
   assign acc_wdata_c = rq.wdata[32'(acc_idx_c)*DW +: DW];

   // Command register, read-tag pipeline and lock FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         ptr_q       <= IW'(NREQ - 1);
         owner_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         tag_vld_q   <= '0;
         for (int i = 0; i <= int'(RD_LAT); i++) tag_id_q[i] <= '0;
      end else begin
         mem_read_q  <= accept_c & ~acc_we_c;
         mem_write_q <= accept_c & acc_we_c;
         if (accept_c) begin
            mem_addr_q <= acc_addr_c;
            mem_din_q  <= acc_wdata_c;
            ptr_q      <= acc_idx_c;
         end
         tag_vld_q   <= {tag_vld_q[RD_LAT-1:0], accept_c & ~acc_we_c};
         tag_id_q[0] <= acc_idx_c;
         for (int i = 1; i <= int'(RD_LAT); i++) tag_id_q[i] <= tag_id_q[i-1];
         case (state_q)
            ST_IDLE: begin
               if (accept_c && acc_lock_c) begin
                  state_q <= ST_LOCKED;
                  owner_q <= acc_idx_c;
               end
            end
            ST_LOCKED: begin
               // Lock is held only while the owner keeps it asserted, with or without a request.
               if (!rq.lock[owner_q]) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rq.gnt    = gnt_c;
   assign rq.rvalid = tag_vld_q[RD_LAT] ? ({{(NREQ-1){1'b0}}, 1'b1} << tag_id_q[RD_LAT]) : '0;
   assign rq.rdata  = tag_vld_q[RD_LAT] ? mem_dout : '0;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
endmodule

// File: tb/tb_grid_port_arbiter.sv
// Bench for grid_port_arbiter: vector table for grants, scoreboard queues for RAM commands
// and read returns, plus a hand-written reset-during-read sequence.
module tb_grid_port_arbiter;
   localparam int unsigned NREQ   = 2;
   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam int unsigned RD_LAT = 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   grid_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   grid_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .rq        (bus.slave),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  we;
      logic [1:0]  lock;
      logic [31:0] a0;
      logic [31:0] d0;
      logic [31:0] a1;
      logic [31:0] d1;
      logic [1:0]  egnt;
   } vec_t;

   typedef struct {
      int          due;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] din;
   } cmd_t;

   typedef struct {
      int          due;
      logic [1:0]  tag;
      logic [31:0] data;
   } rd_t;

   vec_t        tv   [$];
   cmd_t        cmdq [$];
   rd_t         rdq  [$];
   logic [31:0] ram     [16];
   logic [31:0] ref_mem [16];
   bit          ram_init = 1'b0;
   int          cyc      = 0;
   int          nchecks  = 0;
   int          nerr     = 0;

   function automatic logic [31:0] pat(int i);
      return (i == 5) ? 32'hFFFF_FFFF : 32'h100 + 32'(i) * 32'd17;
   endfunction

   // Single-port RAM with one cycle of read latency; loads its pattern on the first edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!ram_init) begin
         for (int i = 0; i < 16; i++) ram[i] <= pat(i);
         ram_init <= 1'b1;
      end else begin
         if (mem_write) ram[mem_addr[3:0]] <= mem_din;
         if (mem_read)  mem_dout <= ram[mem_addr[3:0]];
      end
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      cmd_t c;
      rd_t  r;
      if (reset) begin
         if (mem_read || mem_write) begin
            check("cmd_exclusive", 64'(mem_read & mem_write), 64'd0);
            if (cmdq.size() == 0) begin
               nchecks++;
               nerr++;
               $display("FAIL cmd_unexpected: got command at cycle %0d expected none", cyc);
            end else begin
               c = cmdq.pop_front();
               check("cmd_cycle", 64'(cyc), 64'(c.due));
               check("cmd_write", 64'(mem_write), 64'(c.wr));
               check("cmd_addr", 64'(mem_addr), 64'(c.addr));
               if (c.wr) check("cmd_din", 64'(mem_din), 64'(c.din));
            end
         end
         if (bus.rvalid != '0) begin
            if (rdq.size() == 0) begin
               nchecks++;
               nerr++;
               $display("FAIL rd_unexpected: got rvalid %0h at cycle %0d expected none", bus.rvalid, cyc);
            end else begin
               r = rdq.pop_front();
               check("rd_cycle", 64'(cyc), 64'(r.due));
               check("rd_tag", 64'(bus.rvalid), 64'(r.tag));
               check("rd_data", 64'(bus.rdata), 64'(r.data));
            end
         end
      end
   end

   function automatic vec_t mk(logic [1:0] req, logic [1:0] we, logic [1:0] lock,
                               logic [31:0] a0, logic [31:0] d0,
                               logic [31:0] a1, logic [31:0] d1, logic [1:0] egnt);
      vec_t v;
      v.req = req; v.we = we; v.lock = lock;
      v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.egnt = egnt;
      return v;
   endfunction

   // Drive one cycle, check the same-cycle grant, and book the expected RAM effects.
   task automatic apply(vec_t v, bit rd_ret);
      int          k;
      logic        we_k;
      logic [31:0] addr_k;
      logic [31:0] din_k;
      bus.req   = v.req;
      bus.we    = v.we;
      bus.lock  = v.lock;
      bus.addr  = {v.a1, v.a0};
      bus.wdata = {v.d1, v.d0};
      #1;
      check($sformatf("gnt@cyc%0d", cyc), 64'(bus.gnt), 64'(v.egnt));
      if (v.egnt != 2'b00) begin
         k      = v.egnt[1] ? 1 : 0;
         we_k   = v.we[k];
         addr_k = (k == 1) ? v.a1 : v.a0;
         din_k  = (k == 1) ? v.d1 : v.d0;
         cmdq.push_back('{due: cyc + 1, wr: we_k, addr: addr_k, din: din_k});
         if (we_k) ref_mem[addr_k[3:0]] = din_k;
         else if (rd_ret)
            rdq.push_back('{due: cyc + 1 + int'(RD_LAT), tag: v.egnt, data: ref_mem[addr_k[3:0]]});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      bus.req   = 2'b11;
      bus.we    = 2'b00;
      bus.lock  = 2'b00;
      bus.addr  = '0;
      bus.wdata = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = pat(i);

      // Round robin (first read is addr 5 holding -1)
      tv.push_back(mk(2'b11, 2'b00, 2'b00,  5, 0,  6, 0, 2'b01));
      tv.push_back(mk(2'b11, 2'b00, 2'b00,  7, 0,  6, 0, 2'b10));
      tv.push_back(mk(2'b11, 2'b00, 2'b00,  7, 0,  8, 0, 2'b01));
      tv.push_back(mk(2'b11, 2'b00, 2'b00,  9, 0,  8, 0, 2'b10));
      tv.push_back(mk(2'b01, 2'b00, 2'b00,  9, 0,  0, 0, 2'b01));
      tv.push_back(mk(2'b00, 2'b00, 2'b00,  0, 0,  0, 0, 2'b00));
      // Write then read back on requester 1, then contention after a req0 write
      tv.push_back(mk(2'b10, 2'b10, 2'b00,  0, 0,  3, 7, 2'b10));
      tv.push_back(mk(2'b10, 2'b00, 2'b00,  0, 0,  3, 0, 2'b10));
      tv.push_back(mk(2'b01, 2'b01, 2'b00,  4, 32'hAB, 0, 0, 2'b01));
      tv.push_back(mk(2'b11, 2'b00, 2'b00,  4, 0,  4, 0, 2'b10));
      tv.push_back(mk(2'b01, 2'b00, 2'b00,  4, 0,  4, 0, 2'b01));
      tv.push_back(mk(2'b00, 2'b00, 2'b00,  0, 0,  0, 0, 2'b00));
      // Locked read-check-write of cell 12 with requester 1 waiting to write it
      tv.push_back(mk(2'b01, 2'b00, 2'b01, 12, 0,  0, 0, 2'b01));
      tv.push_back(mk(2'b10, 2'b10, 2'b01, 12, 0, 12, 32'h55, 2'b00));
      tv.push_back(mk(2'b10, 2'b10, 2'b01, 12, 0, 12, 32'h55, 2'b00));
      tv.push_back(mk(2'b11, 2'b11, 2'b00, 12, 32'h99, 12, 32'h55, 2'b01));
      tv.push_back(mk(2'b10, 2'b10, 2'b00,  0, 0, 12, 32'h55, 2'b10));
      tv.push_back(mk(2'b01, 2'b00, 2'b00, 12, 0,  0, 0, 2'b01));
      // Owner drops lock without a transaction
      tv.push_back(mk(2'b10, 2'b00, 2'b10,  0, 0,  2, 0, 2'b10));
      tv.push_back(mk(2'b01, 2'b00, 2'b00,  2, 0,  2, 0, 2'b00));
      tv.push_back(mk(2'b01, 2'b00, 2'b00,  2, 0,  2, 0, 2'b01));
      tv.push_back(mk(2'b00, 2'b00, 2'b00,  0, 0,  0, 0, 2'b00));

      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", 64'(bus.gnt), 64'd0);
      check("rst_mem_read", 64'(mem_read), 64'd0);
      check("rst_mem_write", 64'(mem_write), 64'd0);
      check("rst_rvalid", 64'(bus.rvalid), 64'd0);
      check("rst_rdata", 64'(bus.rdata), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      reset = 1'b1;

      foreach (tv[i]) apply(tv[i], 1'b1);

      // Reset lands in the cycle after mem_read: the read must never come back
      apply(mk(2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 2'b01), 1'b0);
      bus.req = 2'b00;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("midrst_rvalid", 64'(bus.rvalid), 64'd0);
      check("midrst_rdata", 64'(bus.rdata), 64'd0);
      check("midrst_mem_read", 64'(mem_read), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (4) apply(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00), 1'b1);
      apply(mk(2'b11, 2'b00, 2'b00, 1, 0, 2, 0, 2'b01), 1'b1);
      apply(mk(2'b11, 2'b00, 2'b00, 3, 0, 2, 0, 2'b10), 1'b1);
      repeat (4) apply(mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00), 1'b1);

      check("cmdq_drained", 64'(cmdq.size()), 64'd0);
      check("rdq_drained", 64'(rdq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end
endmodule
